// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader that fills the core's instruction memory from address 0, then releases the core.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int IM_DEPTH = 32,
  parameter int AW       = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [7:0]    im_wdata,
  output logic          core_run,
  output logic          load_done,
  output logic          load_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DRAIN = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [7:0] LP_MAX_LEN = 8'(IM_DEPTH);

  state_t        r_state;
  logic [AW:0]   r_len;
  logic [AW:0]   r_cnt;
  logic          r_im_we;
  logic [AW-1:0] r_im_addr;
  logic [7:0]    r_im_wdata;
  logic [AW:0]   w_cnt_nxt;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]    r_csum;

  function automatic logic [7:0] f_csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  assign w_cnt_nxt = r_cnt + {{AW{1'b0}}, 1'b1};

  // Status and handshake outputs are decoded straight from the state register
  assign in_ready  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHECK);
  assign core_run  = (r_state == S_RUN);
  assign load_done = (r_state == S_RUN);
  assign load_err  = (r_state == S_ERR);
  assign im_we     = r_im_we;
  assign im_addr   = r_im_addr;
  assign im_wdata  = r_im_wdata;

  // Loader FSM with counters and the registered memory write port
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_len      <= {(AW+1){1'b0}};
      r_cnt      <= {(AW+1){1'b0}};
      r_im_we    <= 1'b0;
      r_im_addr  <= {AW{1'b0}};
      r_im_wdata <= 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      r_im_we <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            r_state <= S_LEN;
            r_cnt   <= {(AW+1){1'b0}};
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum  <= 8'h00;
`endif
          end
        end
        S_LEN: begin
          if (in_valid) begin
            r_len <= in_data[AW:0];
            if ((in_data == 8'h00) || (in_data > LP_MAX_LEN)) begin
              r_state <= S_ERR;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (in_valid) begin
            r_im_we    <= 1'b1;
            r_im_addr  <= r_cnt[AW-1:0];
            r_im_wdata <= in_data;
            r_cnt      <= w_cnt_nxt;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum     <= f_csum_add(r_csum, in_data);
            if (w_cnt_nxt == r_len) begin
              r_state <= S_CHECK;
            end
`else
            if (w_cnt_nxt == r_len) begin
              r_state <= S_DRAIN;
            end
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (in_valid) begin
            r_state <= (in_data == r_csum) ? S_DRAIN : S_ERR;
          end
        end
`endif
        // Lets the last memory write land before the core starts fetching
        S_DRAIN: r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that sits directly upstream of the 8-bit single-cycle core's instruction memory. It accepts a length-prefixed program image over a valid/ready byte interface and writes it into the 32-entry instruction memory from address 0 upward. It then releases the core by asserting `core_run`. While loading, or after a failed load, the core is held (`core_run` low).

## Interface
Parameters:
- `IM_DEPTH`, 32: instruction memory depth; the maximum program length.
- `AW`, 5: instruction memory address width; `2**AW` must be at least `IM_DEPTH`.

Ports (name, direction, width, meaning):
- `CLK`, input, 1: single clock; all logic is rising-edge.
- `RST_N`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: one-cycle request to begin a load.
- `in_valid`, input, 1: upstream byte valid.
- `in_data`, input, 8: upstream byte.
- `in_ready`, output, 1: loader can accept a byte.
- `im_we`, output, 1: instruction memory write enable.
- `im_addr`, output, `AW`: instruction memory write address.
- `im_wdata`, output, 8: instruction word, packed {opcode[2:0], rd, rs, imm[2:0]}.
- `core_run`, output, 1: core may fetch and execute; when low, the core holds its PC at 0.
- `load_done`, output, 1: last load completed successfully.
- `load_err`, output, 1: last load failed (bad length or checksum mismatch).

## Operation
- A byte transfers on a rising edge where `in_valid && in_ready`. `in_data` is ignored otherwise.
- States: IDLE, LEN, DATA, CHECK, DRAIN, RUN, ERR. `in_ready` = 1 only in LEN, DATA and CHECK.
- IDLE, RUN, ERR: `start` = 1 → LEN. On this transition, clear `load_done`, `load_err`, the byte counter, the address counter and the checksum accumulator. `start` is ignored in every other state.
- LEN: the accepted byte is the length N.
  - 1 ≤ N ≤ `IM_DEPTH` → DATA.
  - N = 0 or N > `IM_DEPTH` → ERR.
- DATA: each accepted byte is written to `im_addr` = k, k = 0..N-1 in order.
  - The byte is added to the checksum accumulator (8-bit, mod 256).
  - After the N-th accepted byte → CHECK.
- CHECK: one byte is accepted.
  - Equal to the accumulator → DRAIN.
  - Not equal → ERR.
- DRAIN: a single cycle → RUN. Its purpose is to let the final `im_we` commit before the core fetches.
- RUN: `core_run` = 1, `load_done` = 1.
- ERR: `load_err` = 1, `core_run` = 0.
- Entries at addresses ≥ N are never written; they keep their prior contents.
- `start` in RUN or ERR reloads: `core_run` drops the cycle after `start`.

## Timing
- Reset (`RST_N` = 0 at an edge) puts the loader in IDLE with all outputs 0: `in_ready`, `im_we`, `im_addr` = 0, `im_wdata` = 0, `core_run`, `load_done`, `load_err`.
- Reset mid-load abandons the load. A partially written memory is left as is, and the next load restarts at address 0.
- All outputs are registered, or decoded directly from the state register; there is no combinational path from inputs to outputs.
- `im_we` pulses for 1 cycle, one cycle after each accepted DATA byte, carrying that byte's address and data.
- Back-to-back: one byte per cycle is sustained with `in_valid` held high. Upstream may deassert `in_valid` at any time; no state advances without a transfer.
- The edge accepting the final byte moves the state to DRAIN. `core_run`/`load_done` rise 2 cycles after that edge.
- ERR is entered on the accepting edge; `load_err` is high from the next cycle.
- Data-path counters are `AW+1` bits wide so that N = 32 does not wrap. `im_addr` never exceeds N-1.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined: behaviour as above; the image is LEN, N data bytes, then the checksum byte.
- Not defined: the CHECK state and the accumulator are removed. After the N-th data byte the loader goes directly to DRAIN. The image is LEN plus N data bytes; `load_err` asserts only for a bad length.

## Test plan
- Load 3 bytes: `start`, then bytes 0x03, 0x41, 0x82, 0x1F, and checksum 0xE2 (checksum build) → writes addr0 = 0x41, addr1 = 0x82, addr2 = 0x1F; `core_run` = 1 and `load_done` = 1 two cycles after the last byte.
- Checksum 0xE3 instead of 0xE2 → `load_err` = 1, `core_run` stays 0; the three writes still occurred.
- Length byte 0x00, then 0x21 on a second `start` → ERR both times, zero `im_we` pulses.
- Length 0x20 with 32 bytes 0x00..0x1F, `in_valid` toggled every other cycle → 32 writes at addr 0..31, no wrap, correct checksum 0xF0 → RUN.
- Reset asserted after the 2nd data byte of a 4-byte load, then a new 1-byte load of 0x55 → written at addr 0, outputs zero during reset.
- `start` pulsed during DATA → ignored; `start` during RUN → `core_run` drops next cycle and a new load proceeds.
